// File: rtl/irq_arb_if.sv
// Signal bundle between the interrupt arbiter and its surroundings.
// out_CNT exists only when IRQ_ARB_COUNT_EN is defined.
interface irq_arb_if;
  logic [2:0]  in_IRQ;
  logic [2:0]  in_MASK;
  logic        in_NIE;
  logic [3:0]  in_IG;
  logic        out_BK;
  logic [1:0]  out_code;
  logic [2:0]  out_PEND;
  logic [2:0]  out_INS;
`ifdef IRQ_ARB_COUNT_EN
  logic [23:0] out_CNT;

  modport master (
    output in_IRQ, in_MASK, in_NIE, in_IG,
    input  out_BK, out_code, out_PEND, out_INS, out_CNT
  );

  modport slave (
    input  in_IRQ, in_MASK, in_NIE, in_IG,
    output out_BK, out_code, out_PEND, out_INS, out_CNT
  );
`else
  modport master (
    output in_IRQ, in_MASK, in_NIE, in_IG,
    input  out_BK, out_code, out_PEND, out_INS
  );

  modport slave (
    input  in_IRQ, in_MASK, in_NIE, in_IG,
    output out_BK, out_code, out_PEND, out_INS
  );
`endif
endinterface

// File: rtl/irq_arb.sv
// Three-line prioritised interrupt arbiter with nesting on in-service level.
// Optional per-line service counters are built when IRQ_ARB_COUNT_EN is defined.
module irq_arb (
  input  logic     in_CLK,
  input  logic     in_RST,
  irq_arb_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [2:0] irq_d_r, edge_r;
  logic [2:0] pend_r, pend_s;
  logic [2:0] ins_r, ins_s;
  logic [2:0] elig_s, clr_s;
  logic [1:0] sel_r, sel_s;
  logic [1:0] level_s;
  logic [1:0] code_r, code_s;
  logic       bk_r, bk_s;
  logic       unused_ig_s;

  // Code of the highest set bit, 0 when none is set.
  function automatic logic [1:0] hi_code(input logic [2:0] v);
    if (v[2]) begin
      hi_code = 2'd3;
    end else if (v[1]) begin
      hi_code = 2'd2;
    end else if (v[0]) begin
      hi_code = 2'd1;
    end else begin
      hi_code = 2'd0;
    end
  endfunction

  function automatic logic [2:0] code_to_oh(input logic [1:0] c);
    case (c)
      2'd1:    code_to_oh = 3'b001;
      2'd2:    code_to_oh = 3'b010;
      2'd3:    code_to_oh = 3'b100;
      default: code_to_oh = 3'b000;
    endcase
  endfunction

  assign unused_ig_s = bus.in_IG[3];

  // Eligibility against the current in-service level, then FSM and flag updates.
  always_comb begin
    level_s   = hi_code(ins_r);
    elig_s[0] = pend_r[0] & ~bus.in_MASK[0] & (level_s == 2'd0);
    elig_s[1] = pend_r[1] & ~bus.in_MASK[1] & (level_s <  2'd2);
    elig_s[2] = pend_r[2] & ~bus.in_MASK[2] & (level_s <  2'd3);
    state_s   = state_r;
    sel_s     = sel_r;
    bk_s      = 1'b0;
    code_s    = 2'd0;
    clr_s     = 3'b000;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_NIE && (elig_s != 3'b000)) begin
          state_s = ST_ISSUE;
          sel_s   = hi_code(elig_s);
          bk_s    = 1'b1;
          code_s  = hi_code(elig_s);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Mask is not re-checked here so an issue in flight always completes.
        clr_s   = code_to_oh(sel_r);
        state_s = ST_BUSY;
      end
      ST_BUSY: begin
        if (!bus.in_NIE) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    pend_s = (pend_r & ~clr_s) | edge_r;
    // Issue set is applied after completion clear so the set wins on a tie.
    ins_s  = (ins_r & ~bus.in_IG[2:0]) | clr_s;
  end

  // State, flags, edge detector and registered outputs.
  always_ff @(posedge in_CLK) begin
    if (!in_RST) begin
      state_r <= ST_IDLE;
      irq_d_r <= bus.in_IRQ;
      edge_r  <= 3'b000;
      pend_r  <= 3'b000;
      ins_r   <= 3'b000;
      sel_r   <= 2'd0;
      bk_r    <= 1'b0;
      code_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      irq_d_r <= bus.in_IRQ;
      edge_r  <= bus.in_IRQ & ~irq_d_r;
      pend_r  <= pend_s;
      ins_r   <= ins_s;
      sel_r   <= sel_s;
      bk_r    <= bk_s;
      code_r  <= code_s;
    end
  end

  assign bus.out_BK   = bk_r;
  assign bus.out_code = code_r;
  assign bus.out_PEND = pend_r;
  assign bus.out_INS  = ins_r;

`ifdef IRQ_ARB_COUNT_EN
  logic [23:0] cnt_r;

  // Per-line service counters, bumped in the ISSUE cycle and wrapping at 255.
  always_ff @(posedge in_CLK) begin
    if (!in_RST) begin
      cnt_r <= 24'd0;
    end else if (state_r == ST_ISSUE) begin
      case (sel_r)
        2'd1:    cnt_r[7:0]   <= cnt_r[7:0]   + 8'd1;
        2'd2:    cnt_r[15:8]  <= cnt_r[15:8]  + 8'd1;
        2'd3:    cnt_r[23:16] <= cnt_r[23:16] + 8'd1;
        default: cnt_r        <= cnt_r;
      endcase
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.out_CNT = cnt_r;
`endif

endmodule
